// File: rtl/trb_bus_pkg.sv
// trb_bus_pkg: shared definitions for the TRB register-bus master.
// Holds the master FSM state encoding, the 2-bit response status codes
// and the bus width constants used by the interface and the RTL.
package trb_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_ACK  = 2'b00;
    localparam logic [1:0] ST_NACK = 2'b01;
    localparam logic [1:0] ST_UNK  = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

endpackage

// File: rtl/trb_reg_master_if.sv
// trb_reg_master_if: TRB slow-control register bus between a master and a
// register slave (e.g. ComTrans).
//   addr    : bus address             (master -> slave)
//   data    : bus write data          (master -> slave)
//   wr / rd : single-cycle strobes    (master -> slave)
//   rdata   : slave read data         (slave -> master)
//   ack / nack / unknown : terminating replies (slave -> master)
interface trb_reg_master_if;
    import trb_bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              nack;
    logic              unknown;

    modport master (
        output addr, data, wr, rd,
        input  rdata, ack, nack, unknown
    );

    modport slave (
        input  addr, data, wr, rd,
        output rdata, ack, nack, unknown
    );

endinterface

// File: rtl/trb_timeout_cnt.sv
// trb_timeout_cnt: reply-timeout counter for the TRB register master.
//   clk : clock
//   rst : synchronous active-high reset
//   clr : synchronous clear (wins over en)
//   en  : count enable; the counter holds once it reaches TIMEOUT-1
//   tc  : terminal count, high while count == TIMEOUT-1
module trb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/trb_reg_master.sv
// trb_reg_master: TRB slow-control register-bus initiator.
// Accepts one read/write command, strobes wr or rd for one cycle, waits for
// unknown/nack/ack (that priority) or a timeout, then presents a response.
// Optional feature macro: TRB_MASTER_RETRY_EN -- reissue on nack up to
// MAX_RETRY times, with one idle cycle before each reissue.
// Ports:
//   Cclk, rst                 : bus clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : command handshake
//   rsp_valid/ready/status/rdata     : response handshake
//   bus                       : register bus (master modport)
module trb_reg_master
    import trb_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic               Cclk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [DATA_W-1:0]  rsp_rdata,
    trb_reg_master_if.master   bus
);

    state_t state;
    logic   is_write;
    logic   tmo;

    trb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk (Cclk),
        .rst (rst),
        .clr (state == S_ISSUE),
        .en  (state == S_WAIT),
        .tc  (tmo)
    );

`ifdef TRB_MASTER_RETRY_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
    logic [3:0] retry_cnt;
    // A reissue enters ISSUE with gap set: that first ISSUE cycle keeps the
    // strobes low, the following one carries the strobe.
    logic       gap;
`else
    logic unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
`endif

    always_ff @(posedge Cclk) begin
        if (rst) begin
            state      <= S_IDLE;
            is_write   <= 1'b0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_ACK;
            rsp_rdata  <= '0;
            bus.addr   <= '0;
            bus.data   <= '0;
            bus.wr     <= 1'b0;
            bus.rd     <= 1'b0;
`ifdef TRB_MASTER_RETRY_EN
            retry_cnt  <= '0;
            gap        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        is_write  <= cmd_write;
                        bus.addr  <= cmd_addr;
                        bus.data  <= cmd_wdata;
                        bus.wr    <= cmd_write;
                        bus.rd    <= !cmd_write;
                        cmd_ready <= 1'b0;
                        rsp_rdata <= '0;
`ifdef TRB_MASTER_RETRY_EN
                        retry_cnt <= '0;
                        gap       <= 1'b0;
`endif
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
`ifdef TRB_MASTER_RETRY_EN
                    if (gap) begin
                        gap    <= 1'b0;
                        bus.wr <= is_write;
                        bus.rd <= !is_write;
                    end else
`endif
                    begin
                        bus.wr <= 1'b0;
                        bus.rd <= 1'b0;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.unknown) begin
                        rsp_status <= ST_UNK;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (bus.nack) begin
`ifdef TRB_MASTER_RETRY_EN
                        if (retry_cnt != RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            gap       <= 1'b1;
                            state     <= S_ISSUE;
                        end else
`endif
                        begin
                            rsp_status <= ST_NACK;
                            rsp_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                    end else if (bus.ack) begin
                        rsp_status <= ST_ACK;
                        if (!is_write) begin
                            rsp_rdata <= bus.rdata;
                        end
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (tmo) begin
                        rsp_status <= ST_TMO;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_status <= ST_ACK;
                        rsp_rdata  <= '0;
                        bus.addr   <= '0;
                        bus.data   <= '0;
                        cmd_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trb_reg_master.sv
// tb_trb_reg_master: directed self-checking bench for trb_reg_master with
// TIMEOUT=8 and MAX_RETRY=2. Retry expectations follow TRB_MASTER_RETRY_EN.
module tb_trb_reg_master;
    import trb_bus_pkg::*;

    logic        Cclk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;

    trb_reg_master_if bus();

    trb_reg_master #(.TIMEOUT(8), .MAX_RETRY(2)) dut (
        .Cclk       (Cclk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_rdata  (rsp_rdata),
        .bus        (bus)
    );

    always #5 Cclk = ~Cclk;

    int errors = 0;
    int checks = 0;

    // Strobe monitor: pulse counts and protocol violations.
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    int   viol      = 0;
    logic wr_q      = 1'b0;
    logic rd_q      = 1'b0;

    always @(posedge Cclk) begin
        if (bus.wr === 1'b1) wr_pulses <= wr_pulses + 1;
        if (bus.rd === 1'b1) rd_pulses <= rd_pulses + 1;
        if ((bus.wr === 1'b1 && bus.rd === 1'b1) ||
            (bus.wr === 1'b1 && wr_q === 1'b1) ||
            (bus.rd === 1'b1 && rd_q === 1'b1))
            viol <= viol + 1;
        wr_q <= bus.wr;
        rd_q <= bus.rd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Cclk);
        #1;
    endtask

    // Presents a command for one edge; returns just after the accepting edge.
    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, rsp_valid, 1'b0);
        chk({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
        chk({tag, "_addr_idle"}, bus.addr, 16'h0000);
    endtask

    int snap;

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        bus.rdata   = '0;
        bus.ack     = 1'b0;
        bus.nack    = 1'b0;
        bus.unknown = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_status", rsp_status, 2'b00);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_wr_rd", {bus.wr, bus.rd}, 2'b00);
        chk("rst_addr_data", {bus.addr, bus.data}, 48'h0);

        // Read 0x00C1, ack two cycles after rd
        snap = rd_pulses;
        send(1'b0, 16'h00C1, 32'h0);
        chk("rd_strobe", {bus.wr, bus.rd}, 2'b01);
        chk("rd_addr", bus.addr, 16'h00C1);
        chk("rd_cmd_ready_low", cmd_ready, 1'b0);
        tick();
        chk("rd_strobe_off", bus.rd, 1'b0);
        tick();
        bus.ack   = 1'b1;
        bus.rdata = 32'h0000_0040;
        tick();
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        chk("rd_valid", rsp_valid, 1'b1);
        chk("rd_status", rsp_status, ST_ACK);
        chk("rd_rdata", rsp_rdata, 32'h0000_0040);
        chk("rd_pulses", rd_pulses - snap, 1);
        finish_rsp("rd");

        // Write 0x00C2 <- 0x80000000, minimum latency, then 5 cycles backpressure
        snap = wr_pulses;
        send(1'b1, 16'h00C2, 32'h8000_0000);
        chk("wr_strobe", {bus.wr, bus.rd}, 2'b10);
        tick();
        chk("wr_data_wait", bus.data, 32'h8000_0000);
        chk("wr_valid_early", rsp_valid, 1'b0);
        bus.ack   = 1'b1;
        bus.rdata = 32'hFFFF_FFFF;
        tick();
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        chk("wr_valid_minlat", rsp_valid, 1'b1);
        chk("wr_status", rsp_status, ST_ACK);
        chk("wr_rdata_zero", rsp_rdata, 32'h0);
        chk("wr_pulses", wr_pulses - snap, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_data", bus.data, 32'h8000_0000);
            chk("bp_status_rdata", {rsp_status, rsp_rdata}, 34'h0);
        end
        finish_rsp("wr");
        chk("wr_data_idle", bus.data, 32'h0);

        // Unknown address
        send(1'b0, 16'h1234, 32'h0);
        tick();
        bus.unknown = 1'b1;
        tick();
        bus.unknown = 1'b0;
        chk("unk_valid", rsp_valid, 1'b1);
        chk("unk_status", rsp_status, ST_UNK);
        chk("unk_rdata", rsp_rdata, 32'h0);
        finish_rsp("unk");

        // nack + unknown in the same cycle: unknown wins
        send(1'b0, 16'h1235, 32'h0);
        tick();
        bus.unknown = 1'b1;
        bus.nack    = 1'b1;
        tick();
        bus.unknown = 1'b0;
        bus.nack    = 1'b0;
        chk("prio_valid", rsp_valid, 1'b1);
        chk("prio_status", rsp_status, ST_UNK);
        finish_rsp("prio");

        // Timeout: rsp_valid visible from acceptance + TIMEOUT + 2 = 10 cycles
        send(1'b0, 16'hABCD, 32'h0);
        for (int i = 0; i < 8; i++) tick();
        chk("tmo_not_yet", rsp_valid, 1'b0);
        tick();
        chk("tmo_valid", rsp_valid, 1'b1);
        chk("tmo_status", rsp_status, ST_TMO);
        bus.ack   = 1'b1;
        bus.rdata = 32'hDEAD_BEEF;
        tick();
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        chk("late_ack_status", rsp_status, ST_TMO);
        chk("late_ack_rdata", rsp_rdata, 32'h0);
        finish_rsp("tmo");

        // Normal command after a timeout
        send(1'b0, 16'h0055, 32'h0);
        tick();
        bus.ack   = 1'b1;
        bus.rdata = 32'h1234_5678;
        tick();
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        chk("post_tmo_status", rsp_status, ST_ACK);
        chk("post_tmo_rdata", rsp_rdata, 32'h1234_5678);
        finish_rsp("post_tmo");

`ifdef TRB_MASTER_RETRY_EN
        // nack, nack, ack -> three strobes with one idle cycle before each reissue
        snap = rd_pulses;
        send(1'b0, 16'h0077, 32'h0);
        tick();
        bus.nack = 1'b1;
        tick();
        bus.nack = 1'b0;
        chk("rty_gap1", bus.rd, 1'b0);
        chk("rty_gap1_valid", rsp_valid, 1'b0);
        tick();
        chk("rty_strobe2", bus.rd, 1'b1);
        tick();
        bus.nack = 1'b1;
        tick();
        bus.nack = 1'b0;
        chk("rty_gap2", bus.rd, 1'b0);
        tick();
        chk("rty_strobe3", bus.rd, 1'b1);
        tick();
        bus.ack   = 1'b1;
        bus.rdata = 32'h0000_00A5;
        tick();
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        chk("rty_valid", rsp_valid, 1'b1);
        chk("rty_status", rsp_status, ST_ACK);
        chk("rty_rdata", rsp_rdata, 32'h0000_00A5);
        chk("rty_pulses", rd_pulses - snap, 3);
        finish_rsp("rty");

        // Always nack -> three strobes, status nack
        snap = rd_pulses;
        send(1'b0, 16'h0078, 32'h0);
        bus.nack = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("rtyn_not_yet", rsp_valid, 1'b0);
        tick();
        bus.nack = 1'b0;
        chk("rtyn_valid", rsp_valid, 1'b1);
        chk("rtyn_status", rsp_status, ST_NACK);
        chk("rtyn_pulses", rd_pulses - snap, 3);
        finish_rsp("rtyn");
`else
        // No retry: first nack terminates
        snap = rd_pulses;
        send(1'b0, 16'h0078, 32'h0);
        tick();
        bus.nack = 1'b1;
        tick();
        bus.nack = 1'b0;
        chk("nack_valid", rsp_valid, 1'b1);
        chk("nack_status", rsp_status, ST_NACK);
        chk("nack_pulses", rd_pulses - snap, 1);
        finish_rsp("nack");
`endif

        // Reset during WAIT aborts with no response and no re-strobe
        snap = rd_pulses;
        send(1'b0, 16'h0099, 32'h1111_2222);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_outputs", {bus.wr, bus.rd, bus.addr, bus.data, rsp_status, rsp_rdata}, 84'h0);
        bus.ack = 1'b1;
        tick();
        tick();
        bus.ack = 1'b0;
        chk("abort_no_rsp", rsp_valid, 1'b0);
        chk("abort_pulses", rd_pulses - snap, 1);

        chk("strobe_protocol", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trb_reg_master.md
# trb_reg_master

Register-bus initiator for the TRB slow-control interface: the bus master that drives the `data`/`addr`/`wr`/`rd` signals a register slave such as `ComTrans` consumes, and collects `rdata`/`ack`/`nack`/`unknown`. It accepts one read or write command at a time from an upstream command source (test sequencer, UART bridge, self-test controller) and strobes the bus. It waits for a terminating reply or a timeout, then returns a status and read data. It sits in the bus clock domain `Cclk` and drives the slave's register port directly.

## Interface
- `TIMEOUT`, 64: cycles to wait after the strobe for a reply before declaring timeout; legal range 2..65535.
- `MAX_RETRY`, 3: reissues after a `nack`; used only when retry is compiled in; legal range 0..15.
- `Cclk` in 1: bus clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 16: register address.
- `cmd_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: upstream consumes response.
- `rsp_status` out 2: 00 ack, 01 nack, 10 unknown, 11 timeout.
- `rsp_rdata` out 32: captured `rdata` for read-ack; 0 otherwise.
- `addr` out 16: bus address.
- `data` out 32: bus write data.
- `wr` out 1: write strobe.
- `rd` out 1: read strobe.
- `rdata` in 32: slave read data.
- `ack` in 1: slave acknowledge.
- `nack` in 1: slave refusal.
- `unknown` in 1: slave reports an unmapped address.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch write flag, address and data, then go to ISSUE.
- ISSUE (exactly one cycle):
  - Assert `wr` (write) or `rd` (read) for this single cycle.
  - Drive `addr`/`data` from the latch.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Sample `ack`/`nack`/`unknown` every cycle.
  - If two or more are high together, the first in this order wins: `unknown`, `nack`, `ack`.
  - On a winner, record status; on read-ack, capture `rdata` that same cycle. Then go to RESP.
  - The counter increments every WAIT cycle. When it reaches `TIMEOUT`-1 with no reply, record status 11 and go to RESP.
- RESP:
  - `rsp_valid`=1, with status and data held stable.
  - On `rsp_ready`, go to IDLE.
- `addr`/`data` stay stable from ISSUE through the end of RESP. They return to 0 in IDLE.
- `ack`/`nack`/`unknown` are ignored in IDLE, ISSUE and RESP; late replies after a timeout are discarded.
- Write-ack returns `rsp_rdata`=0.

## Timing
- Reset: in the cycle after `rst` is sampled high, every output is 0 except `cmd_ready`, which is 1.
- Reset mid-transaction aborts it with no response. Strobes are never re-asserted for the aborted command.
- Minimum latency:
  - Command accepted at edge N.
  - Strobe during cycle N+1.
  - Slave reply seen at N+2.
  - `rsp_valid` high from N+3.
- Timeout: `rsp_valid` rises `TIMEOUT`+2 cycles after acceptance when no reply arrives.
- `cmd_ready` is low from acceptance until the response handshake completes. A new command can be accepted the cycle after `rsp_valid & rsp_ready`.
- `wr` and `rd` are never high together and never high for more than one consecutive cycle per issue.

## Configuration
- `TRB_MASTER_RETRY_EN` defined:
  - A `nack` in WAIT does not go to RESP. Instead the block returns to ISSUE after one idle cycle with strobes low, and reissues the same command.
  - This repeats up to `MAX_RETRY` times.
  - If the final attempt is still `nack`, the response is status 01.
  - `ack`, `unknown` and timeout terminate immediately.
  - The timeout counter restarts on each reissue.
- Undefined: the first `nack` goes straight to RESP. `MAX_RETRY` has no effect and the retry counter is not built.

## Structure
- Package `trb_bus_pkg` holds:
  - the FSM state enum;
  - the 2-bit status codes: `ST_ACK`, `ST_NACK`, `ST_UNK`, `ST_TMO`;
  - bus width constants: 16-bit address, 32-bit data.
- One sub-module, `trb_timeout_cnt`: a clear/enable counter with a terminal-count flag, parameterised by `TIMEOUT`.
- The FSM, latches and retry logic live in the top.

## Test plan
- Read: command read at 0x00C1; slave returns `ack` with `rdata`=0x00000040 two cycles after `rd` -> one `rd` pulse, `addr`=0x00C1, `rsp_status`=00, `rsp_rdata`=0x00000040.
- Write: command write 0x00C2 ← 0x80000000; slave acks -> one `wr` pulse, `data`=0x80000000 stable until the response, `rsp_status`=00, `rsp_rdata`=0.
- Unknown address: read at 0x1234 with slave `unknown` -> status 10. Same-cycle `nack`+`unknown` -> status 10.
- Timeout: no reply with `TIMEOUT`=8 -> status 11 at acceptance+10 cycles. A late `ack` afterwards is ignored and a new command is accepted normally.
- Retry: macro on, `MAX_RETRY`=2, slave nacks twice then acks -> three strobes, each separated by WAIT plus one idle cycle, final status 00. Always-nack -> three strobes, status 01. Macro off -> one strobe, status 01.
- Reset and backpressure: assert `rst` during WAIT -> no `rsp_valid`, all outputs 0, `cmd_ready`=1. Hold `rsp_ready` low for 5 cycles -> response stays stable and `cmd_ready` stays 0.
